// File: rtl/aes128_dec_iter_if.sv
// Handshake bundle for the iterative AES-128 decryptor: ciphertext/key in, plaintext out.
interface aes128_dec_iter_if;
  localparam int unsigned W = 128;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_key;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Forward-expands the cipher key to rk10, then unwinds the schedule while decrypting.
// Optional last-key cache: define AES_DEC_KEY_CACHE_EN to skip expansion on a repeated key.
module aes128_dec_iter #(
  parameter bit ZERO_IDLE_OUT = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  aes128_dec_iter_if.slave    bus,
  output logic                busy
);
  localparam int unsigned W  = 128;
  localparam int unsigned CW = 4;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] ISBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_t;

  // Table entry 0 sits in the top byte, so entry b is at bit offset (255-b)*8.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] b);
    return ISBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant as a sum of b, 2b, 4b, 8b.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] c);
    case (c)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [W-1:0] key_fwd(input logic [W-1:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [W-1:0] key_inv(input logic [W-1:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows then InvSubBytes; byte 4c+r of the block is row r, column c.
  function automatic logic [W-1:0] inv_shift_sub(input logic [W-1:0] s);
    logic [W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = isbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
    return o;
  endfunction

  function automatic logic [W-1:0] inv_mix(input logic [W-1:0] s);
    logic [W-1:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  fsm_t          fsm_q, fsm_d;
  logic [W-1:0]  rk_q, rk_d, st_q, st_d, out_data_q, out_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [W-1:0]  prev, fwd, t;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [W-1:0]  cache_key_q, cache_key_d, cache_rk10_q, cache_rk10_d;
  logic          cache_vld_q, cache_vld_d;
`endif

  // Next-state and datapath: ciphertext parks in st_q during key expansion.
  always_comb begin
    fsm_d       = fsm_q;
    rk_d        = rk_q;
    st_d        = st_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    prev        = key_inv(rk_q, rcon(cnt_q));
    fwd         = key_fwd(rk_q, rcon(cnt_q));
    t           = inv_shift_sub(st_q) ^ prev;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_key_d  = cache_key_q;
    cache_rk10_d = cache_rk10_q;
    cache_vld_d  = cache_vld_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_vld_q && (bus.in_key == cache_key_q)) begin
            rk_d  = cache_rk10_q;
            st_d  = bus.in_data ^ cache_rk10_q;
            cnt_d = CW'(10);
            fsm_d = ROUND;
          end else begin
            cache_key_d = bus.in_key;
            cache_vld_d = 1'b0;
            rk_d        = bus.in_key;
            st_d        = bus.in_data;
            cnt_d       = CW'(1);
            fsm_d       = KEXP;
          end
`else
          rk_d  = bus.in_key;
          st_d  = bus.in_data;
          cnt_d = CW'(1);
          fsm_d = KEXP;
`endif
        end
      end
      KEXP: begin
        rk_d = fwd;
        if (cnt_q == CW'(10)) begin
          st_d  = st_q ^ fwd;
          fsm_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_rk10_d = fwd;
          cache_vld_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ROUND: begin
        rk_d  = prev;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          st_d        = t;
          out_data_d  = t;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end else begin
          st_d = inv_mix(t);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (ZERO_IDLE_OUT) out_data_d = '0;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    in_ready_d = (fsm_d == IDLE);
    busy_d     = (fsm_d != IDLE);
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q       <= IDLE;
      rk_q        <= '0;
      st_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_q  <= '0;
      cache_rk10_q <= '0;
      cache_vld_q  <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      rk_q        <= rk_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_q  <= cache_key_d;
      cache_rk10_q <= cache_rk10_d;
      cache_vld_q  <= cache_vld_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_aes128_dec_iter.sv
// Directed bench for aes128_dec_iter using FIPS-197 vectors.
module tb_aes128_dec_iter;
  logic clk;
  logic resetn;
  logic busy;
  int   checks;
  int   failures;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes128_dec_iter_if bus ();

  aes128_dec_iter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One block: offer, optionally inject ignored traffic, measure latency, then drain.
  task automatic xfer(input string tag, input logic [127:0] key, input logic [127:0] data,
                      input logic [127:0] exp_pt, input int exp_lat, input int hold,
                      input bit noise, input bit chk_rk);
    int w;
    int lat;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick;
      w++;
    end
    chk({tag, "/in_ready"}, 128'(bus.in_ready), 128'(1));
    bus.in_valid  = 1'b1;
    bus.in_key    = key;
    bus.in_data   = data;
    bus.out_ready = (hold == 0);
    tick;
    bus.in_valid = 1'b0;
    bus.in_key   = ~key;
    bus.in_data  = ~data;
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      bus.in_valid = noise && (lat >= 2) && (lat <= 16) && (lat % 2 == 1);
      tick;
      lat++;
      if (chk_rk && lat == 10) chk({tag, "/rk10"}, dut.rk_q, R10);
    end
    bus.in_valid = 1'b0;
    chk({tag, "/latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "/plaintext"}, bus.out_data, exp_pt);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, "/hold_valid"}, 128'(bus.out_valid), 128'(1));
      chk({tag, "/hold_data"}, bus.out_data, exp_pt);
      chk({tag, "/hold_in_ready"}, 128'(bus.in_ready), 128'(0));
      chk({tag, "/hold_busy"}, 128'(busy), 128'(1));
    end
    bus.out_ready = 1'b1;
    tick;
    chk({tag, "/valid_drop"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "/data_zero"}, bus.out_data, 128'(0));
    chk({tag, "/ready_back"}, 128'(bus.in_ready), 128'(1));
    chk({tag, "/busy_off"}, 128'(busy), 128'(0));
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    clk           = 1'b0;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_key    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst/in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst/out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst/out_data", bus.out_data, 128'(0));
    chk("rst/busy", 128'(busy), 128'(0));
    tick;
    resetn = 1'b1;
    tick;
    tick;
    chk("rst/in_ready_after", 128'(bus.in_ready), 128'(1));

    xfer("v1", K1, C1, P1, 20, 0, 1'b0, 1'b0);
    xfer("v2_bp", K2, C2, P2, 20, 15, 1'b0, 1'b1);

    // Reset pulse eight cycles into a block discards it.
    bus.in_valid = 1'b1;
    bus.in_key   = K1;
    bus.in_data  = C1;
    tick;
    bus.in_valid = 1'b0;
    repeat (8) tick;
    chk("midrst/busy_before", 128'(busy), 128'(1));
    resetn = 1'b0;
    #1;
    chk("midrst/busy", 128'(busy), 128'(0));
    chk("midrst/out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst/out_data", bus.out_data, 128'(0));
    chk("midrst/in_ready", 128'(bus.in_ready), 128'(0));
    tick;
    tick;
    resetn = 1'b1;
    tick;
    tick;

    xfer("v2_after_rst", K2, C2, P2, 20, 0, 1'b0, 1'b1);
    xfer("v1_noise", K1, C1, P1, 20, 0, 1'b1, 1'b0);
    chk("idle/out_valid", 128'(bus.out_valid), 128'(0));

`ifdef AES_DEC_KEY_CACHE_EN
    xfer("cache_miss", K2, C2, P2, 20, 0, 1'b0, 1'b1);
    xfer("cache_hit", K2, C2, P2, 10, 0, 1'b0, 1'b0);
    xfer("cache_newkey", K1, C1, P1, 20, 0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
